// File: rtl/spi_cmd_sequencer.sv
// rtl/spi_cmd_sequencer.sv - SPI command decoder driving a byte-wide register bus.
// First byte of a frame is a command; reads return their data in the following frame.
module spi_cmd_sequencer #(
  parameter int NUM_REGS = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       byte_sync,
  input  logic [7:0] data_in,
  input  logic       cs_idle,
  output logic [7:0] data_out,
  output logic [5:0] reg_addr,
  output logic       reg_wr,
  output logic [7:0] reg_wdata,
  output logic       reg_rd,
  input  logic [7:0] reg_rdata,
  output logic       cmd_err
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_DATA  = 3'd1,
    DISCARD  = 3'd2,
    RD_ISSUE = 3'd3,
    RD_WAIT  = 3'd4
  } state_t;

  localparam logic [6:0] NREGS    = 7'(NUM_REGS);
  localparam logic [5:0] LAST_REG = 6'(NUM_REGS - 1);

  state_t     state_q, state_d;
  logic [5:0] addr_q, addr_d;
  logic       inc_q, inc_d;
  logic [5:0] reg_addr_q, reg_addr_d;
  logic [7:0] reg_wdata_q, reg_wdata_d;
  logic       reg_wr_q, reg_wr_d;
  logic       reg_rd_q, reg_rd_d;
  logic [7:0] data_out_q, data_out_d;
  logic       cmd_err_q, cmd_err_d;

  function automatic logic in_range(input logic [5:0] a);
    return {1'b0, a} < NREGS;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      inc_q       <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_wr_q    <= 1'b0;
      reg_rd_q    <= 1'b0;
      data_out_q  <= 8'h00;
      cmd_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      inc_q       <= inc_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_wr_q    <= reg_wr_d;
      reg_rd_q    <= reg_rd_d;
      data_out_q  <= data_out_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

  // addr_q is the next write target; reg_addr_q is what the bus sees with the strobe.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    inc_d       = inc_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_wr_d    = 1'b0;
    reg_rd_d    = 1'b0;
    data_out_d  = data_out_q;
    cmd_err_d   = cmd_err_q;
    case (state_q)
      IDLE: begin
        if (byte_sync) begin
          addr_d     = data_in[5:0];
          reg_addr_d = data_in[5:0];
          inc_d      = data_in[6];
          if (data_in[7]) begin
            state_d = cs_idle ? IDLE : WR_DATA;
          end else begin
            state_d = RD_ISSUE;
            if (in_range(data_in[5:0])) reg_rd_d = 1'b1;
            else                        cmd_err_d = 1'b1;
          end
        end
      end
      WR_DATA: begin
        if (byte_sync) begin
          reg_addr_d  = addr_q;
          reg_wdata_d = data_in;
          if (in_range(addr_q)) reg_wr_d  = 1'b1;
          else                  cmd_err_d = 1'b1;
          if (inc_q) addr_d = (addr_q == LAST_REG) ? 6'd0 : addr_q + 6'd1;
          else       state_d = DISCARD;
        end
        if (cs_idle) state_d = IDLE;
      end
      DISCARD: begin
        if (cs_idle) state_d = IDLE;
      end
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT: begin
        data_out_d = in_range(reg_addr_q) ? reg_rdata : 8'h00;
        state_d    = DISCARD;
      end
      default: state_d = IDLE;
    endcase
  end

  assign data_out  = data_out_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wr    = reg_wr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_rd    = reg_rd_q;
  assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// tb/tb_spi_cmd_sequencer.sv - bench for spi_cmd_sequencer with 64- and 16-register instances.
module tb_spi_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       byte_sync = 1'b0;
  logic       cs_idle = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic [7:0] dout0, dout1, wdata0, wdata1, rdata0, rdata1;
  logic [5:0] addr0, addr1;
  logic       wr0, wr1, rd0, rd1, err0, err1;

  always #5 clk = ~clk;

  spi_cmd_sequencer #(.NUM_REGS(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .byte_sync(byte_sync), .data_in(data_in), .cs_idle(cs_idle),
    .data_out(dout0), .reg_addr(addr0), .reg_wr(wr0), .reg_wdata(wdata0), .reg_rd(rd0),
    .reg_rdata(rdata0), .cmd_err(err0));

  spi_cmd_sequencer #(.NUM_REGS(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .byte_sync(byte_sync), .data_in(data_in), .cs_idle(cs_idle),
    .data_out(dout1), .reg_addr(addr1), .reg_wr(wr1), .reg_wdata(wdata1), .reg_rd(rd1),
    .reg_rdata(rdata1), .cmd_err(err1));

  int errors = 0;
  int checks = 0;
  int overlap = 0;
  logic mem_init = 1'b0;
  logic [7:0] mem0 [64];
  logic [7:0] mem1 [64];

  // Register files answering each instance: read data appears the cycle after reg_rd.
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 64; i++) begin
        mem0[i] <= 8'(i * 3 + 1);
        mem1[i] <= 8'(i * 3 + 1);
      end
    end else begin
      if (wr0) mem0[addr0] <= wdata0;
      if (wr1) mem1[addr1] <= wdata1;
    end
    if (rd0) rdata0 <= mem0[addr0];
    if (rd1) rdata1 <= mem1[addr1];
  end

  logic [13:0] wq0[$], wq1[$];
  logic [5:0]  rq0[$], rq1[$];
  int ws0, ws1, rs0, rs1;

  always @(negedge clk) begin
    if (wr0) wq0.push_back({addr0, wdata0});
    if (wr1) wq1.push_back({addr1, wdata1});
    if (rd0) rq0.push_back(addr0);
    if (rd1) rq1.push_back(addr1);
    if ((wr0 && rd0) || (wr1 && rd1)) overlap++;
  end

  // Reference model: per-frame transaction rules over a shadow register array.
  logic [7:0] m_mem [2][64];
  logic [7:0] m_dout [2];
  logic       m_err [2];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] v);
    data_in   = v;
    byte_sync = 1'b1;
    step();
    byte_sync = 1'b0;
    repeat (3) step();
  endtask

  task automatic run_frame(input int n, input logic [0:3][7:0] b);
    ws0 = wq0.size(); ws1 = wq1.size();
    rs0 = rq0.size(); rs1 = rq1.size();
    cs_idle = 1'b0;
    repeat (2) step();
    for (int i = 0; i < n; i++) send(b[i]);
    cs_idle = 1'b1;
    repeat (3) step();
  endtask

  task automatic model_check(input int d, input int n, input logic [0:3][7:0] b);
    int nr, a, gw_n, gr_n;
    logic [13:0] ew[$];
    logic [5:0]  er[$];
    nr = (d == 0) ? 64 : 16;
    a  = int'(b[0][5:0]);
    if (b[0][7]) begin
      for (int i = 1; i < n; i++) begin
        if (a < nr) begin
          ew.push_back({6'(a), b[i]});
          m_mem[d][a] = b[i];
        end else m_err[d] = 1'b1;
        if (!b[0][6]) break;
        a = (a == nr - 1) ? 0 : (a + 1) % 64;
      end
    end else if (a < nr) begin
      er.push_back(6'(a));
      m_dout[d] = m_mem[d][a];
    end else begin
      m_err[d]  = 1'b1;
      m_dout[d] = 8'h00;
    end
    gw_n = (d == 0) ? wq0.size() - ws0 : wq1.size() - ws1;
    gr_n = (d == 0) ? rq0.size() - rs0 : rq1.size() - rs1;
    check($sformatf("dut%0d_num_writes", d), 32'(gw_n), 32'(ew.size()));
    for (int i = 0; i < ew.size() && i < gw_n; i++)
      check($sformatf("dut%0d_write%0d", d, i),
            32'((d == 0) ? wq0[ws0 + i] : wq1[ws1 + i]), 32'(ew[i]));
    check($sformatf("dut%0d_num_reads", d), 32'(gr_n), 32'(er.size()));
    if (er.size() > 0 && gr_n > 0)
      check($sformatf("dut%0d_read_addr", d), 32'((d == 0) ? rq0[rs0] : rq1[rs1]), 32'(er[0]));
    check($sformatf("dut%0d_data_out", d), 32'((d == 0) ? dout0 : dout1), 32'(m_dout[d]));
    check($sformatf("dut%0d_cmd_err", d), 32'((d == 0) ? err0 : err1), 32'(m_err[d]));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data_out"},  32'({dout1, dout0}), 32'h0);
    check({tag, "_reg_addr"},  32'({addr1, addr0}), 32'h0);
    check({tag, "_reg_wdata"}, 32'({wdata1, wdata0}), 32'h0);
    check({tag, "_strobes"},   32'({wr1, rd1, wr0, rd0}), 32'h0);
    check({tag, "_cmd_err"},   32'({err1, err0}), 32'h0);
  endtask

  typedef struct {
    int               n;
    logic [0:3][7:0]  b;
    int               nwr;
    logic [0:2][5:0]  wa;
    logic [0:2][7:0]  wd;
    int               nrd;
    logic [5:0]       ra;
    logic [7:0]       d64;
    logic [7:0]       d16;
    logic             e16;
  } vec_t;

  vec_t tbl [11];

  initial begin
    logic [0:3][7:0] fb;
    int nb;

    tbl[0]  = '{2, {8'h85, 8'hA5, 8'h00, 8'h00}, 1, {6'd5, 6'd0, 6'd0},   {8'hA5, 8'h00, 8'h00}, 0, 6'd0,  8'h00, 8'h00, 1'b0};
    tbl[1]  = '{2, {8'h83, 8'h5C, 8'h00, 8'h00}, 1, {6'd3, 6'd0, 6'd0},   {8'h5C, 8'h00, 8'h00}, 0, 6'd0,  8'h00, 8'h00, 1'b0};
    tbl[2]  = '{2, {8'h03, 8'h00, 8'h00, 8'h00}, 0, {6'd0, 6'd0, 6'd0},   {8'h00, 8'h00, 8'h00}, 1, 6'd3,  8'h5C, 8'h5C, 1'b0};
    tbl[3]  = '{2, {8'h94, 8'h77, 8'h00, 8'h00}, 1, {6'd20, 6'd0, 6'd0},  {8'h77, 8'h00, 8'h00}, 0, 6'd0,  8'h5C, 8'h5C, 1'b1};
    tbl[4]  = '{1, {8'h14, 8'h00, 8'h00, 8'h00}, 0, {6'd0, 6'd0, 6'd0},   {8'h00, 8'h00, 8'h00}, 1, 6'd20, 8'h77, 8'h00, 1'b1};
    tbl[5]  = '{4, {8'hFE, 8'h11, 8'h22, 8'h33}, 3, {6'd62, 6'd63, 6'd0}, {8'h11, 8'h22, 8'h33}, 0, 6'd0,  8'h77, 8'h00, 1'b1};
    tbl[6]  = '{3, {8'h45, 8'h99, 8'h98, 8'h00}, 0, {6'd0, 6'd0, 6'd0},   {8'h00, 8'h00, 8'h00}, 1, 6'd5,  8'hA5, 8'hA5, 1'b1};
    tbl[7]  = '{3, {8'h87, 8'h10, 8'h20, 8'h00}, 1, {6'd7, 6'd0, 6'd0},   {8'h10, 8'h00, 8'h00}, 0, 6'd0,  8'hA5, 8'hA5, 1'b1};
    tbl[8]  = '{1, {8'h3E, 8'h00, 8'h00, 8'h00}, 0, {6'd0, 6'd0, 6'd0},   {8'h00, 8'h00, 8'h00}, 1, 6'd62, 8'h11, 8'h00, 1'b1};
    tbl[9]  = '{1, {8'hC0, 8'h00, 8'h00, 8'h00}, 0, {6'd0, 6'd0, 6'd0},   {8'h00, 8'h00, 8'h00}, 0, 6'd0,  8'h11, 8'h00, 1'b1};
    tbl[10] = '{1, {8'h02, 8'h00, 8'h00, 8'h00}, 0, {6'd0, 6'd0, 6'd0},   {8'h00, 8'h00, 8'h00}, 1, 6'd2,  8'h07, 8'h07, 1'b1};

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 64; i++) m_mem[d][i] = 8'(i * 3 + 1);
      m_dout[d] = 8'h00;
      m_err[d]  = 1'b0;
    end

    repeat (3) step();
    check_reset_outputs("reset");
    mem_init = 1'b1;
    rst_n    = 1'b1;
    step();

    for (int k = 0; k < 11; k++) begin
      run_frame(tbl[k].n, tbl[k].b);
      check($sformatf("tbl%0d_num_writes", k), 32'(wq0.size() - ws0), 32'(tbl[k].nwr));
      for (int j = 0; j < tbl[k].nwr && j < wq0.size() - ws0; j++)
        check($sformatf("tbl%0d_write%0d", k, j), 32'(wq0[ws0 + j]), 32'({tbl[k].wa[j], tbl[k].wd[j]}));
      check($sformatf("tbl%0d_num_reads", k), 32'(rq0.size() - rs0), 32'(tbl[k].nrd));
      if (tbl[k].nrd > 0 && rq0.size() > rs0)
        check($sformatf("tbl%0d_read_addr", k), 32'(rq0[rs0]), 32'(tbl[k].ra));
      check($sformatf("tbl%0d_dout64", k), 32'(dout0), 32'(tbl[k].d64));
      check($sformatf("tbl%0d_dout16", k), 32'(dout1), 32'(tbl[k].d16));
      check($sformatf("tbl%0d_err16", k), 32'(err1), 32'(tbl[k].e16));
      check($sformatf("tbl%0d_err64", k), 32'(err0), 32'h0);
      model_check(0, tbl[k].n, tbl[k].b);
      model_check(1, tbl[k].n, tbl[k].b);
    end

    // Cycle-exact read latency: command in cycle N, strobe in N+1, data_out from N+3.
    cs_idle = 1'b0;
    step();
    data_in   = 8'h03;
    byte_sync = 1'b1;
    step();
    byte_sync = 1'b0;
    check("lat_rd_n1", 32'({rd0, addr0}), 32'({1'b1, 6'd3}));
    check("lat_dout_n1", 32'(dout0), 32'h07);
    step();
    check("lat_rd_n2", 32'(rd0), 32'h0);
    check("lat_dout_n2", 32'(dout0), 32'h07);
    step();
    check("lat_dout_n3", 32'({dout1, dout0}), 32'h5C5C);
    send(8'h00);
    cs_idle = 1'b1;
    repeat (3) step();
    check("lat_dout_after_cs", 32'({dout1, dout0}), 32'h5C5C);
    m_dout[0] = m_mem[0][3];
    m_dout[1] = m_mem[1][3];
    fb = {8'h8A, 8'h55, 8'h00, 8'h00};
    run_frame(2, fb);
    model_check(0, 2, fb);
    model_check(1, 2, fb);

    for (int k = 0; k < 60; k++) begin
      nb = int'($urandom_range(1, 4));
      for (int i = 0; i < 4; i++) fb[i] = 8'($urandom);
      run_frame(nb, fb);
      model_check(0, nb, fb);
      model_check(1, nb, fb);
    end

    // Reset in the middle of an auto-increment burst.
    ws0 = wq0.size(); ws1 = wq1.size();
    rs0 = rq0.size(); rs1 = rq1.size();
    cs_idle = 1'b0;
    step();
    send(8'hC8);
    send(8'h01);
    send(8'h02);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    send(8'h03);
    rst_n   = 1'b1;
    cs_idle = 1'b1;
    repeat (3) step();
    check_reset_outputs("after_reset");
    check("midreset_writes64", 32'(wq0.size() - ws0), 32'd2);
    check("midreset_writes16", 32'(wq1.size() - ws1), 32'd2);
    check("midreset_reads", 32'((rq0.size() - rs0) + (rq1.size() - rs1)), 32'd0);
    for (int d = 0; d < 2; d++) begin
      m_mem[d][8] = 8'h01;
      m_mem[d][9] = 8'h02;
      m_dout[d]   = 8'h00;
      m_err[d]    = 1'b0;
    end
    fb = {8'h09, 8'h00, 8'h00, 8'h00};
    run_frame(1, fb);
    model_check(0, 1, fb);
    model_check(1, 1, fb);

    check("strobe_overlap", 32'(overlap), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
